// File: rtl/reg_arith_bank.sv
// reg_arith_bank: small bank of loop/pointer registers with INCR, DECR, LOAD
// and branch-target computation (JIZR/JNZR) behind a valid/ready handshake.
// Results are registered one cycle after acceptance and held under
// consumer back-pressure; accept and consume may coincide for full throughput.
// Optional feature macro: REG_ARITH_SAT_EN (saturating INCR/DECR plus 'sat' port).
module reg_arith_bank #(
    parameter int WIDTH    = 8,
    parameter int NREGS    = 4,
    parameter int OFFW     = 3,
    parameter int ZERO_OFF = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op,
    input  logic [$clog2(NREGS)-1:0] sel,
    input  logic [OFFW-1:0]          off,
    input  logic [WIDTH-1:0]         pc,
    input  logic [WIDTH-1:0]         ld_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res,
    output logic                     res_zero,
    output logic                     br_taken,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [WIDTH-1:0]         rd_data
`ifdef REG_ARITH_SAT_EN
    ,
    output logic                     sat
`endif
);

    localparam int SELW = $clog2(NREGS);

    localparam logic [2:0] OP_INCR = 3'b001;
    localparam logic [2:0] OP_DECR = 3'b010;
    localparam logic [2:0] OP_JIZR = 3'b011;
    localparam logic [2:0] OP_JNZR = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;

    localparam logic [WIDTH-1:0] L_ZERO_OFF = WIDTH'(ZERO_OFF);

    logic [WIDTH-1:0] w_bank [NREGS];
    logic [WIDTH-1:0] w_cur;
    logic             w_accept;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_val;
    logic             w_has_res;
    logic [WIDTH-1:0] w_res_next;
    logic             w_zero_next;
    logic             w_br_next;
    logic             w_sat_next;
    logic [WIDTH-1:0] w_disp;
    logic [WIDTH-1:0] w_tgt;

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_res_zero;
    logic             r_br_taken;
    logic             r_sat;

    assign w_cur    = w_bank[sel];
    assign rd_data  = w_bank[rd_sel];

    // Ready whenever the output slot is empty or being drained this cycle.
    assign op_ready = !reset && (!r_res_valid || res_ready);
    assign w_accept = op_valid && op_ready;

    // A zero offset would be a jump-to-self, so substitute a fixed displacement.
    assign w_disp = (off != '0) ? WIDTH'({off, 1'b0}) : L_ZERO_OFF;
    // Branch target always wraps; the carry is dropped by truncation.
    assign w_tgt  = pc + w_disp;

`ifdef REG_ARITH_SAT_EN
    // Extra bit exposes carry/borrow so the saturating path can detect the limit.
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    assign w_inc = {1'b0, w_cur} + (WIDTH+1)'(1);
    assign w_dec = {1'b0, w_cur} - (WIDTH+1)'(1);
`else
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    assign w_inc = w_cur + WIDTH'(1);
    assign w_dec = w_cur - WIDTH'(1);
`endif

    // Decode the operation into a bank write and the next result fields.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_val    = w_cur;
        w_has_res   = 1'b0;
        w_res_next  = r_res;
        w_zero_next = r_res_zero;
        w_br_next   = 1'b0;
        w_sat_next  = 1'b0;
        case (op)
            OP_INCR: begin
                w_wr_en   = 1'b1;
                w_has_res = 1'b1;
`ifdef REG_ARITH_SAT_EN
                if (w_inc[WIDTH]) begin
                    w_wr_val   = w_cur;
                    w_sat_next = 1'b1;
                end else begin
                    w_wr_val = w_inc[WIDTH-1:0];
                end
`else
                w_wr_val  = w_inc;
`endif
            end
            OP_DECR: begin
                w_wr_en   = 1'b1;
                w_has_res = 1'b1;
`ifdef REG_ARITH_SAT_EN
                if (w_dec[WIDTH]) begin
                    w_wr_val   = w_cur;
                    w_sat_next = 1'b1;
                end else begin
                    w_wr_val = w_dec[WIDTH-1:0];
                end
`else
                w_wr_val  = w_dec;
`endif
            end
            OP_LOAD: begin
                w_wr_en   = 1'b1;
                w_has_res = 1'b1;
                w_wr_val  = ld_data;
            end
            OP_JIZR: begin
                w_has_res = 1'b1;
                w_br_next = (w_cur == '0);
            end
            OP_JNZR: begin
                w_has_res = 1'b1;
                w_br_next = (w_cur != '0);
            end
            default: begin
                w_has_res = 1'b0;
            end
        endcase
        if (w_wr_en) begin
            w_res_next  = w_wr_val;
            w_zero_next = (w_wr_val == '0);
        end else if (w_has_res) begin
            w_res_next  = w_tgt;
            w_zero_next = (w_cur == '0);
        end
    end

    // Result register: load on accepted result-producing ops, clear valid on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_res_zero  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_accept && w_has_res) begin
            r_res_valid <= 1'b1;
            r_res       <= w_res_next;
            r_res_zero  <= w_zero_next;
            r_br_taken  <= w_br_next;
            r_sat       <= w_sat_next;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // One register per bank entry; written on the same edge as the result.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_bank
            logic [WIDTH-1:0] r_entry;
            // Entry update on an accepted write to this index.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_entry <= '0;
                end else if (w_accept && w_wr_en && (sel == SELW'(gi))) begin
                    r_entry <= w_wr_val;
                end
            end
            assign w_bank[gi] = r_entry;
        end
    endgenerate

    assign res_valid = r_res_valid;
    assign res       = r_res;
    assign res_zero  = r_res_zero;
    assign br_taken  = r_br_taken;
`ifdef REG_ARITH_SAT_EN
    assign sat       = r_sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = r_sat;
`endif

endmodule

// File: tb/tb_reg_arith_bank.sv
// Testbench for reg_arith_bank: directed steps with a result scoreboard.
module tb_reg_arith_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op;
    logic [1:0] sel;
    logic [2:0] off;
    logic [7:0] pc;
    logic [7:0] ld_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res;
    logic       res_zero;
    logic       br_taken;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
`ifdef REG_ARITH_SAT_EN
    logic       sat;
`endif

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] INCR = 3'b001;
    localparam logic [2:0] DECR = 3'b010;
    localparam logic [2:0] JIZR = 3'b011;
    localparam logic [2:0] JNZR = 3'b100;
    localparam logic [2:0] LOAD = 3'b101;

    typedef struct packed {
        logic [7:0] r;
        logic       z;
        logic       b;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_bank [4];
    logic       m_valid;
    int         checks = 0;
    int         errors = 0;

    reg_arith_bank #(.WIDTH(8), .NREGS(4), .OFFW(3), .ZERO_OFF(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .sel(sel), .off(off), .pc(pc), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .res_zero(res_zero), .br_taken(br_taken), .rd_sel(rd_sel),
        .rd_data(rd_data)
`ifdef REG_ARITH_SAT_EN
        , .sat(sat)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Read every bank entry through the debug port and compare to the model.
    task automatic check_bank(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            chk($sformatf("%s_bank%0d", tag, i), {24'd0, rd_data}, {24'd0, m_bank[i]});
        end
    endtask

    // One cycle: drive at negedge, check outputs, update scoreboard, advance.
    task automatic step(input logic v, input logic [2:0] o, input logic [1:0] s,
                        input logic [2:0] f, input logic [7:0] p, input logic [7:0] d,
                        input logic rr, input logic [7:0] er, input logic ez,
                        input logic eb);
        exp_t e;
        logic acc;
        op_valid = v; op = o; sel = s; off = f; pc = p; ld_data = d; res_ready = rr;
        #1;
        chk("op_ready", {31'd0, op_ready}, {31'd0, (!m_valid || rr)});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
        if (m_valid && q.size() > 0) begin
            e = q[0];
            chk("res", {24'd0, res}, {24'd0, e.r});
            chk("res_zero", {31'd0, res_zero}, {31'd0, e.z});
            chk("br_taken", {31'd0, br_taken}, {31'd0, e.b});
            if (rr) begin
                void'(q.pop_front());
                $display("TXN res=%02h zero=%0d br=%0d", res, res_zero, br_taken);
            end
        end
        acc = v && (!m_valid || rr);
        if (acc) begin
            if (o >= INCR && o <= LOAD) begin
                q.push_back('{r: er, z: ez, b: eb});
                m_valid = 1'b1;
                if (o == INCR || o == DECR || o == LOAD) m_bank[s] = er;
            end else begin
                m_valid = 1'b0;
            end
        end else if (rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, NOP, 2'd0, 3'd0, 8'h00, 8'h00, rr, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
        q.delete();
        m_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = NOP; sel = 2'd0; off = 3'd0;
        pc = 8'h00; ld_data = 8'h00; res_ready = 1'b0; rd_sel = 2'd0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("ready_in_reset", {31'd0, op_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, op_ready}, 32'd1);
        chk("rst_res", {24'd0, res}, 32'd0);
        chk("rst_zero", {31'd0, res_zero}, 32'd0);
        chk("rst_br", {31'd0, br_taken}, 32'd0);
        check_bank("rst");

        // 1: load then count down to zero back-to-back
        step(1, LOAD, 2'd2, 3'd0, 8'h00, 8'h05, 1, 8'h05, 0, 0);
        step(1, DECR, 2'd2, 3'd0, 8'h00, 8'h00, 1, 8'h04, 0, 0);
        step(1, DECR, 2'd2, 3'd0, 8'h00, 8'h00, 1, 8'h03, 0, 0);
        step(1, DECR, 2'd2, 3'd0, 8'h00, 8'h00, 1, 8'h02, 0, 0);
        step(1, DECR, 2'd2, 3'd0, 8'h00, 8'h00, 1, 8'h01, 0, 0);
        step(1, DECR, 2'd2, 3'd0, 8'h00, 8'h00, 1, 8'h00, 1, 0);
        idle(1);
        check_bank("t1");

        // 2: wrap (or saturate) at both ends
        step(1, LOAD, 2'd1, 3'd0, 8'h00, 8'hFF, 1, 8'hFF, 0, 0);
`ifdef REG_ARITH_SAT_EN
        step(1, INCR, 2'd1, 3'd0, 8'h00, 8'h00, 1, 8'hFF, 0, 0);
        chk("sat_incr", {31'd0, sat}, 32'd1);
        step(1, DECR, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 1, 0);
        chk("sat_decr", {31'd0, sat}, 32'd1);
`else
        step(1, INCR, 2'd1, 3'd0, 8'h00, 8'h00, 1, 8'h00, 1, 0);
        step(1, DECR, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'hFF, 0, 0);
`endif
        step(1, LOAD, 2'd0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 1, 0);

        // 3: branch targets with bank[0]==0
        step(1, JIZR, 2'd0, 3'd3, 8'h40, 8'h00, 1, 8'h46, 1, 1);
        step(1, JNZR, 2'd0, 3'd3, 8'h40, 8'h00, 1, 8'h46, 1, 0);
        step(1, JIZR, 2'd0, 3'd0, 8'h40, 8'h00, 1, 8'h50, 1, 1);

        // 4: target wraps, branch register untouched
        step(1, LOAD, 2'd3, 3'd0, 8'h00, 8'h01, 1, 8'h01, 0, 0);
        step(1, JNZR, 2'd3, 3'd7, 8'hF8, 8'h00, 1, 8'h06, 0, 1);
        idle(1);
        check_bank("t4");

        // 5: back-pressure holds the result and blocks issue
        step(1, INCR, 2'd3, 3'd0, 8'h00, 8'h00, 0, 8'h02, 0, 0);
        step(1, INCR, 2'd3, 3'd0, 8'h00, 8'h00, 0, 8'h03, 0, 0);
        step(1, INCR, 2'd3, 3'd0, 8'h00, 8'h00, 0, 8'h03, 0, 0);
        step(1, INCR, 2'd3, 3'd0, 8'h00, 8'h00, 0, 8'h03, 0, 0);
        step(1, INCR, 2'd3, 3'd0, 8'h00, 8'h00, 1, 8'h03, 0, 0);
        step(1, 3'b110, 2'd3, 3'd0, 8'h00, 8'h00, 1, 8'h00, 0, 0);
        idle(1);
        check_bank("t5");

        // 6: reset mid-transaction discards result and concurrent op
        step(1, LOAD, 2'd1, 3'd0, 8'h00, 8'h33, 0, 8'h33, 0, 0);
        chk("t6_valid_before", {31'd0, res_valid}, 32'd1);
        reset = 1'b1; op_valid = 1'b1; op = LOAD; sel = 2'd2; ld_data = 8'h99; res_ready = 1'b0;
        #1;
        chk("t6_ready_in_reset", {31'd0, op_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; op_valid = 1'b0;
        model_clear();
        #1;
        chk("t6_valid", {31'd0, res_valid}, 32'd0);
        chk("t6_res", {24'd0, res}, 32'd0);
        chk("t6_ready", {31'd0, op_ready}, 32'd1);
        check_bank("t6");
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
